// File: rtl/disp_pkg.sv
// disp_pkg: shared constants, state type and anode helper for the display scan slice
package disp_pkg;
   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W = 4;
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'hF;
   typedef enum logic [1:0] {IDLE, BLANK, ON} stateT;
   function automatic logic [NUM_DIGITS-1:0] anodeOn(input logic [1:0] sel);
      return ~(NUM_DIGITS'(1) << sel);
   endfunction
endpackage

// File: rtl/disp_slot_timer.sv
// disp_slot_timer: per-digit slot counter; phase_on looks one cycle ahead so the caller can register its anodes
module disp_slot_timer #(
   parameter int CLK_DIV = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic run,
   output logic phase_on,
   output logic slot_end
);
   localparam int W = $clog2(CLK_DIV);
   logic [W-1:0] cnt;
   assign slot_end = run && cnt == W'(CLK_DIV - 1);
   // true when the cycle after this edge lies in the lit part of the slot
   assign phase_on = run && !slot_end && cnt >= W'(DEAD_CYCLES - 1);
   always_ff @(posedge clock)
      cnt <= reset || !run || slot_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: 4-digit scan with dead-time and frame-aligned double buffering
// DISP_LZ_BLANK_EN: keep digits above the highest nonzero nibble dark
module disp_scan_ctrl
   import disp_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DEAD_CYCLES = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           enable,
   input  logic [NUM_DIGITS*DIGIT_W-1:0]  value_in,
   input  logic                           load,
   output logic                           load_ack,
   output logic [1:0]                     scan,
   output logic [DIGIT_W-1:0]             digit_out,
   output logic [NUM_DIGITS-1:0]          anode_n,
   output logic                           frame_done
);
   stateT state;
   logic run, phaseOn, slotEnd, pending, lit;
   logic [NUM_DIGITS*DIGIT_W-1:0] shadow, active;
   assign run = enable && state != IDLE;
   assign frame_done = slotEnd && &scan;
   assign digit_out = DIGIT_W'(active >> {scan, 2'b00});
`ifdef DISP_LZ_BLANK_EN
   assign lit = scan == 2'd0 || |(active >> {scan, 2'b00});
`else
   assign lit = 1'b1;
`endif
   disp_slot_timer #(.CLK_DIV(CLK_DIV), .DEAD_CYCLES(DEAD_CYCLES)) uTimer (
      .clock(clock),
      .reset(reset),
      .run(run),
      .phase_on(phaseOn),
      .slot_end(slotEnd)
   );
   // scan only moves at a slot end, so it is already the next cycle's digit whenever phaseOn is set
   always_ff @(posedge clock)
      if (reset) begin
         state <= IDLE;
         scan <= 2'd0;
         anode_n <= ANODE_OFF;
         shadow <= '0;
         active <= '0;
         pending <= 1'b0;
         load_ack <= 1'b0;
      end else begin
         state <= !enable ? IDLE : phaseOn ? ON : BLANK;
         scan <= run ? scan + 2'(slotEnd) : 2'd0;
         anode_n <= phaseOn && lit ? anodeOn(scan) : ANODE_OFF;
         shadow <= load ? value_in : shadow;
         active <= frame_done && pending ? shadow : active;
         pending <= load || (pending && !frame_done);
         load_ack <= frame_done && pending;
      end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: vector table, corner sequences and a frame-position reference model
module tb_disp_scan_ctrl;
   localparam int CD = 8;
   localparam int DC = 2;
`ifdef DISP_LZ_BLANK_EN
   localparam bit LZ = 1'b1;
`else
   localparam bit LZ = 1'b0;
`endif
   logic clock, reset, enable, load, load_ack, frame_done;
   logic [15:0] value_in;
   logic [1:0] scan;
   logic [3:0] digit_out, anode_n;
   int total = 0;
   int bad = 0;

   disp_scan_ctrl #(.CLK_DIV(CD), .DEAD_CYCLES(DC)) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .value_in(value_in),
      .load(load),
      .load_ack(load_ack),
      .scan(scan),
      .digit_out(digit_out),
      .anode_n(anode_n),
      .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

   typedef struct {
      logic en;
      logic ld;
      logic [15:0] val;
      int n;
      logic [3:0] anode;
      logic [1:0] scn;
      logic [3:0] dig;
      logic fd;
      logic ack;
   } vecT;
   vecT vec[15];

   bit running;
   int pos;
   logic [15:0] mAct, mShd;
   bit mPend, mAck;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic waitFd();
      int k = 0;
      @(negedge clock);
      while (!frame_done && k < 100) begin
         @(negedge clock);
         k++;
      end
      check("wait_frame_done", 16'(frame_done), 16'd1);
   endtask

   task automatic pulseLoad(input logic [15:0] v);
      @(negedge clock);
      load = 1'b1;
      value_in = v;
      @(posedge clock);
      #1 load = 1'b0;
   endtask

   task automatic readFrame(output logic [15:0] v);
      waitFd();
      for (int s = 0; s < 4; s++) begin
         @(posedge clock);
         #1 v[4*s +: 4] = digit_out;
         repeat (7) @(posedge clock);
      end
   endtask

   task automatic checkReset(input string nm);
      check({nm, "_anode"}, 16'(anode_n), 16'hF);
      check({nm, "_scan"}, 16'(scan), 16'd0);
      check({nm, "_digit"}, 16'(digit_out), 16'd0);
      check({nm, "_ack"}, 16'(load_ack), 16'd0);
      check({nm, "_fd"}, 16'(frame_done), 16'd0);
   endtask

   initial begin
      logic [15:0] v;
      int acks;
      bit found;
      reset = 1'b1;
      enable = 1'b0;
      load = 1'b0;
      value_in = '0;
      repeat (3) @(posedge clock);
      #1 checkReset("reset");
      vec[0]  = '{1'b1, 1'b0, 16'h0,    1,  4'hF,              2'd0, 4'h0, 1'b0, 1'b0};
      vec[1]  = '{1'b1, 1'b0, 16'h0,    1,  4'hF,              2'd0, 4'h0, 1'b0, 1'b0};
      vec[2]  = '{1'b1, 1'b0, 16'h0,    1,  4'hE,              2'd0, 4'h0, 1'b0, 1'b0};
      vec[3]  = '{1'b1, 1'b0, 16'h0,    5,  4'hE,              2'd0, 4'h0, 1'b0, 1'b0};
      vec[4]  = '{1'b1, 1'b0, 16'h0,    1,  4'hF,              2'd1, 4'h0, 1'b0, 1'b0};
      vec[5]  = '{1'b1, 1'b0, 16'h0,    2,  LZ ? 4'hF : 4'hD,  2'd1, 4'h0, 1'b0, 1'b0};
      vec[6]  = '{1'b1, 1'b1, 16'h1234, 1,  LZ ? 4'hF : 4'hD,  2'd1, 4'h0, 1'b0, 1'b0};
      vec[7]  = '{1'b1, 1'b0, 16'h0,    8,  LZ ? 4'hF : 4'hB,  2'd2, 4'h0, 1'b0, 1'b0};
      vec[8]  = '{1'b1, 1'b0, 16'h0,    11, LZ ? 4'hF : 4'h7,  2'd3, 4'h0, 1'b0, 1'b0};
      vec[9]  = '{1'b1, 1'b0, 16'h0,    1,  LZ ? 4'hF : 4'h7,  2'd3, 4'h0, 1'b1, 1'b0};
      vec[10] = '{1'b1, 1'b0, 16'h0,    1,  4'hF,              2'd0, 4'h4, 1'b0, 1'b1};
      vec[11] = '{1'b1, 1'b0, 16'h0,    1,  4'hF,              2'd0, 4'h4, 1'b0, 1'b0};
      vec[12] = '{1'b1, 1'b0, 16'h0,    8,  4'hF,              2'd1, 4'h3, 1'b0, 1'b0};
      vec[13] = '{1'b1, 1'b0, 16'h0,    8,  4'hF,              2'd2, 4'h2, 1'b0, 1'b0};
      vec[14] = '{1'b1, 1'b0, 16'h0,    8,  4'hF,              2'd3, 4'h1, 1'b0, 1'b0};
      for (int r = 0; r < 15; r++) begin
         @(negedge clock);
         reset = 1'b0;
         enable = vec[r].en;
         load = vec[r].ld;
         value_in = vec[r].val;
         for (int i = 0; i < vec[r].n; i++) begin
            @(posedge clock);
            #1 load = 1'b0;
         end
         check($sformatf("vec%0d_anode", r), 16'(anode_n), 16'(vec[r].anode));
         check($sformatf("vec%0d_scan", r), 16'(scan), 16'(vec[r].scn));
         check($sformatf("vec%0d_digit", r), 16'(digit_out), 16'(vec[r].dig));
         check($sformatf("vec%0d_fd", r), 16'(frame_done), 16'(vec[r].fd));
         check($sformatf("vec%0d_ack", r), 16'(load_ack), 16'(vec[r].ack));
      end
      // two loads in one frame: one ack, last value wins
      waitFd();
      pulseLoad(16'hAAAA);
      repeat (4) @(posedge clock);
      pulseLoad(16'h5555);
      acks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         acks += int'(load_ack);
      end
      check("dbl_load_acks", 16'(acks), 16'd1);
      readFrame(v);
      check("dbl_load_value", v, 16'h5555);
      // load landing on the frame_done cycle
      repeat (3) @(posedge clock);
      pulseLoad(16'h1111);
      waitFd();
      load = 1'b1;
      value_in = 16'h9876;
      @(posedge clock);
      #1 load = 1'b0;
      check("coinc_ack1", 16'(load_ack), 16'd1);
      check("coinc_digit1", 16'(digit_out), 16'h1);
      waitFd();
      @(posedge clock);
      #1 check("coinc_ack2", 16'(load_ack), 16'd1);
      check("coinc_digit2", 16'(digit_out), 16'h6);
      // enable dropped while digit 2 is lit
      found = 1'b0;
      for (int k = 0; k < 64 && !found; k++) begin
         @(negedge clock);
         found = scan == 2'd2 && anode_n == 4'hB;
      end
      check("drop_found", 16'(found), 16'd1);
      enable = 1'b0;
      @(posedge clock);
      #1 check("drop_anode", 16'(anode_n), 16'hF);
      check("drop_scan", 16'(scan), 16'd0);
      repeat (3) @(posedge clock);
      @(negedge clock);
      enable = 1'b1;
      @(posedge clock);
      #1 check("reen_blank", 16'(anode_n), 16'hF);
      check("reen_scan", 16'(scan), 16'd0);
      repeat (2) @(posedge clock);
      #1 check("reen_on", 16'(anode_n), 16'hE);
      // leading-zero behaviour
      pulseLoad(16'h0042);
      waitFd();
      repeat (19) @(posedge clock);
      #1 check("lz42_scan", 16'(scan), 16'd2);
      check("lz42_anode", 16'(anode_n), LZ ? 16'hF : 16'hB);
      pulseLoad(16'h0000);
      waitFd();
      repeat (11) @(posedge clock);
      #1 check("lz0_scan", 16'(scan), 16'd1);
      check("lz0_anode", 16'(anode_n), LZ ? 16'hF : 16'hD);
      // mid-frame reset, then randomized run against the model
      @(negedge clock);
      reset = 1'b1;
      load = 1'b1;
      value_in = 16'hBEEF;
      @(posedge clock);
      #1 checkReset("midreset");
      running = 1'b0;
      pos = 0;
      mAct = '0;
      mShd = '0;
      mPend = 1'b0;
      mAck = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         int es, slot;
         logic [3:0] eAn;
         bit eFd, lit;
         @(negedge clock);
         reset = $urandom_range(0, 199) == 0;
         enable = $urandom_range(0, 19) != 0;
         load = $urandom_range(0, 7) == 0;
         value_in = 16'($urandom);
         #1;
         es = running ? pos / CD : 0;
         slot = pos % CD;
         lit = running && slot >= DC && !(LZ && es != 0 && (mAct >> (4 * es)) == 0);
         eAn = lit ? ~(4'b1 << es) : 4'hF;
         eFd = running && enable && pos == 4 * CD - 1;
         check("rnd_anode", 16'(anode_n), 16'(eAn));
         check("rnd_scan", 16'(scan), 16'(es));
         check("rnd_digit", 16'(digit_out), (mAct >> (4 * es)) & 16'hF);
         check("rnd_fd", 16'(frame_done), 16'(eFd));
         check("rnd_ack", 16'(load_ack), 16'(mAck));
         if (reset) begin
            running = 1'b0;
            pos = 0;
            mAct = '0;
            mShd = '0;
            mPend = 1'b0;
            mAck = 1'b0;
         end else begin
            mAck = eFd && mPend;
            if (mAck) mAct = mShd;
            mPend = load || (mPend && !eFd);
            if (load) mShd = value_in;
            if (!enable) begin
               running = 1'b0;
               pos = 0;
            end else if (!running) begin
               running = 1'b1;
               pos = 0;
            end else pos = (pos + 1) % (4 * CD);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
